// File: rtl/bin2bcd_pkg.sv
// Shared constants for the bin2bcd peripheral: bus addresses, register bit
// positions and the conversion FSM state encoding.
package bin2bcd_pkg;

  localparam logic [5:0] ADDR_OPA_LO = 6'h04;
  localparam logic [5:0] ADDR_OPA_HI = 6'h08;
  localparam logic [5:0] ADDR_CTRL   = 6'h0C;
  localparam logic [5:0] ADDR_STATUS = 6'h10;
  localparam logic [5:0] ADDR_RES0   = 6'h14;
  localparam logic [5:0] ADDR_RES1   = 6'h18;
  localparam logic [5:0] ADDR_RES2   = 6'h1C;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_SIGN = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bin2bcd_core.sv
// Sequential double-dabble engine: one operand bit per cycle in SHIFT.
// Define BIN2BCD_SIGNED_EN to treat the operand as two's complement.
module bin2bcd_core
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  operand,
  output logic              busy,
  output logic              done_pulse,
  output logic [4*NDIG-1:0] digits,
  output logic              overflow,
  output logic              sign
);

  state_t            state;
  logic [5:0]        cnt;
  logic [WIDTH-1:0]  bin;
  logic [4*NDIG-1:0] bcd;
  logic [4*NDIG-1:0] adj;
  logic              ovf;
  logic              sgn;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < NDIG; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      sgn   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: begin
          cnt <= '0;
          bcd <= '0;
          ovf <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
          // Negating the most negative value wraps to itself, which read as
          // unsigned is exactly its magnitude.
          sgn <= operand[WIDTH-1];
          bin <= operand[WIDTH-1] ? -operand : operand;
`else
          sgn <= 1'b0;
          bin <= operand;
`endif
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // A set top bit after the +3 adjust is a carry beyond the last digit.
          bcd <= {adj[4*NDIG-2:0], bin[WIDTH-1]};
          bin <= bin << 1;
          ovf <= ovf | adj[4*NDIG-1];
          if (cnt == 6'(WIDTH - 1)) state <= ST_FIN;
          else cnt <= cnt + 6'd1;
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done_pulse = (state == ST_FIN);
  assign digits     = bcd;
  assign overflow   = ovf;
  assign sign       = sgn;

endmodule

// File: rtl/bin2bcd_periph_n.sv
// Bus-facing wrapper: register decode, sticky done, irq and read mux around
// bin2bcd_core. BIN2BCD_SIGNED_EN selects the signed engine build.
module bin2bcd_periph_n
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [5:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        irq
);

  logic              wr_en;
  logic              rd_en;
  logic              start;
  logic              busy;
  logic              done_pulse;
  logic              core_ovf;
  logic              core_sign;
  logic [WIDTH-1:0]  opa;
  logic [4*NDIG-1:0] core_digits;
  logic [4*NDIG-1:0] res_q;
  logic              irq_en_q;
  logic              done_q;
  logic              ovf_q;
  logic              sign_q;
  logic [47:0]       res_wide;
  logic [15:0]       status_word;
  logic [15:0]       rd_data;

  assign wr_en = cs & wr;
  assign rd_en = cs & rd;
  assign start = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START] && !busy;

  bin2bcd_core #(.WIDTH(WIDTH), .NDIG(NDIG)) u_core (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .operand    (opa),
    .busy       (busy),
    .done_pulse (done_pulse),
    .digits     (core_digits),
    .overflow   (core_ovf),
    .sign       (core_sign)
  );

  // Only WIDTH operand bits exist; each comes from the LO or HI write.
  always_ff @(posedge CLK) begin
    if (reset) begin
      opa <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i < 16) ? (addr == ADDR_OPA_LO) : (addr == ADDR_OPA_HI))
          opa[i] <= d_in[i % 16];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      if (wr_en && (addr == ADDR_CTRL) && !(busy && d_in[CTRL_START]))
        irq_en_q <= d_in[CTRL_IRQ_EN];
      // Setting done wins over a coincident STATUS read.
      if (done_pulse) done_q <= 1'b1;
      else if (start || (rd_en && (addr == ADDR_STATUS))) done_q <= 1'b0;
      if (done_pulse) begin
        res_q  <= core_digits;
        ovf_q  <= core_ovf;
        sign_q <= core_sign;
      end
    end
  end

  assign res_wide = 48'(res_q);

  always_comb begin
    status_word            = '0;
    status_word[STAT_DONE] = done_q;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_OVF]  = ovf_q;
    status_word[STAT_SIGN] = sign_q;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: rd_data = status_word;
      ADDR_RES0:   rd_data = res_wide[15:0];
      ADDR_RES1:   rd_data = res_wide[31:16];
      ADDR_RES2:   rd_data = res_wide[47:32];
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) d_out <= '0;
    else if (rd_en) d_out <= rd_data;
  end

  assign irq = done_q & irq_en_q;

endmodule
